// File: rtl/cr_prefix_fe_cmp_multi_pkg.sv
// Shared types for the multi-rule prefix front-end compare: rule modes and
// the frame-tracking state encoding.
package cr_prefix_fe_cmp_multi_pkg;

  localparam int unsigned PREFIX_CMP_MODE_W = 3;

  typedef enum logic [PREFIX_CMP_MODE_W-1:0] {
    CMP_EQ    = 3'd0,
    CMP_GTEQ  = 3'd1,
    CMP_LT    = 3'd2,
    CMP_EQOP  = 3'd3,
    CMP_RANGE = 3'd4,
    CMP_MASK  = 3'd5,
    CMP_RSVD6 = 3'd6,
    CMP_RSVD7 = 3'd7
  } prefix_cmp_mode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } prefix_cmp_fsm_e;

endpackage

// File: rtl/cr_prefix_fe_cmp_multi_rule.sv
// One combinational compare rule: unsigned character test against value v
// and range-high / mask h, selected by mode.
module cr_prefix_fe_cmp_rule
  import cr_prefix_fe_cmp_multi_pkg::*;
#(
  parameter int unsigned CHAR_W = 8
) (
  input  logic [CHAR_W-1:0]            ch,
  input  logic [CHAR_W-1:0]            v,
  input  logic [CHAR_W-1:0]            h,
  input  logic [PREFIX_CMP_MODE_W-1:0] mode,
  output logic                         match
);

  always_comb begin
    match = 1'b0;
    case (prefix_cmp_mode_e'(mode))
      CMP_EQ,
      CMP_EQOP:  match = (ch == v);
      CMP_GTEQ:  match = (ch >= v);
      CMP_LT:    match = (ch < v);
      // v > h leaves the window empty, so no character matches
      CMP_RANGE: match = (ch >= v) && (ch <= h);
      CMP_MASK:  match = ((ch ^ v) & h) == '0;
      default:   match = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr_prefix_fe_cmp_multi.sv
// Multi-rule compare stage: evaluates NUM_CMP rules per accepted beat, tracks
// per-frame hit counts and first-hit positions, one registered output stage.
module cr_prefix_fe_cmp_multi
  import cr_prefix_fe_cmp_multi_pkg::*;
#(
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned NUM_CMP = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CHAR_W-1:0]                      in_char,
  input  logic                                   in_sop,
  input  logic                                   in_eop,
  input  logic [NUM_CMP*CHAR_W-1:0]              match_val,
  input  logic [NUM_CMP*CHAR_W-1:0]              match_hi,
  input  logic [NUM_CMP*PREFIX_CMP_MODE_W-1:0]   cmp_type,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [CHAR_W-1:0]                      out_char,
  output logic                                   out_sop,
  output logic                                   out_eop,
  output logic [NUM_CMP-1:0]                     out_cmp,
  output logic [NUM_CMP*CNT_W-1:0]               out_hit_cnt,
  output logic [NUM_CMP*CNT_W-1:0]               out_first_pos,
  output logic                                   out_err
);

  localparam logic [CNT_W-1:0] POS_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

  logic                                 accept;
  prefix_cmp_fsm_e                      state_q, state_nxt;
  logic [CNT_W-1:0]                     pos_q, pos_nxt;
  logic [NUM_CMP*CNT_W-1:0]             hit_q, hit_nxt;
  logic [NUM_CMP*CNT_W-1:0]             first_q, first_nxt;
  logic [NUM_CMP*CHAR_W-1:0]            sh_val, sh_hi;
  logic [NUM_CMP*PREFIX_CMP_MODE_W-1:0] sh_type;
  logic [NUM_CMP*CHAR_W-1:0]            cfg_val, cfg_hi;
  logic [NUM_CMP*PREFIX_CMP_MODE_W-1:0] cfg_type;
  logic [NUM_CMP-1:0]                   cmp;
  logic                                 err;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // A sop beat compares against the live config, everything else the shadow
  assign cfg_val  = in_sop ? match_val : sh_val;
  assign cfg_hi   = in_sop ? match_hi  : sh_hi;
  assign cfg_type = in_sop ? cmp_type  : sh_type;

  for (genvar g = 0; g < NUM_CMP; g++) begin : g_rule
    cr_prefix_fe_cmp_rule #(.CHAR_W(CHAR_W)) u_rule (
      .ch    (in_char),
      .v     (cfg_val[g*CHAR_W +: CHAR_W]),
      .h     (cfg_hi[g*CHAR_W +: CHAR_W]),
      .mode  (cfg_type[g*PREFIX_CMP_MODE_W +: PREFIX_CMP_MODE_W]),
      .match (cmp[g])
    );
  end

  always_comb begin
    pos_nxt = in_sop ? '0 : ((pos_q == POS_MAX) ? pos_q : pos_q + CNT_W'(1));
    err     = in_sop ? (state_q == IN_FRAME) : (state_q == IDLE);
    if (in_eop)
      state_nxt = IDLE;
    else if (in_sop || state_q == IN_FRAME)
      state_nxt = IN_FRAME;
    else
      state_nxt = IDLE;
  end

  always_comb begin
    hit_nxt   = hit_q;
    first_nxt = first_q;
    for (int unsigned i = 0; i < NUM_CMP; i++) begin
      if (in_sop) begin
        hit_nxt[i*CNT_W +: CNT_W]   = CNT_W'(cmp[i]);
        first_nxt[i*CNT_W +: CNT_W] = cmp[i] ? '0 : '1;
      end else if (cmp[i]) begin
        if (hit_q[i*CNT_W +: CNT_W] != '1)
          hit_nxt[i*CNT_W +: CNT_W] = hit_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        if (first_q[i*CNT_W +: CNT_W] == '1)
          first_nxt[i*CNT_W +: CNT_W] = pos_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pos_q         <= '0;
      hit_q         <= '0;
      first_q       <= '1;
      sh_val        <= '0;
      sh_hi         <= '0;
      sh_type       <= '0;
      out_valid     <= 1'b0;
      out_char      <= '0;
      out_sop       <= 1'b0;
      out_eop       <= 1'b0;
      out_cmp       <= '0;
      out_hit_cnt   <= '0;
      out_first_pos <= '1;
      out_err       <= 1'b0;
    end else if (accept) begin
      state_q       <= state_nxt;
      pos_q         <= pos_nxt;
      hit_q         <= hit_nxt;
      first_q       <= first_nxt;
      if (in_sop) begin
        sh_val  <= match_val;
        sh_hi   <= match_hi;
        sh_type <= cmp_type;
      end
      out_valid     <= 1'b1;
      out_char      <= in_char;
      out_sop       <= in_sop;
      out_eop       <= in_eop;
      out_cmp       <= cmp;
      out_hit_cnt   <= hit_nxt;
      out_first_pos <= first_nxt;
      out_err       <= err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_cmp   <= '0;
    end
  end

endmodule

// File: tb/tb_cr_prefix_fe_cmp_multi.sv
// Directed bench for cr_prefix_fe_cmp_multi; a CNT_W=4 instance shares the
// stimulus to exercise counter saturation.
module tb_cr_prefix_fe_cmp_multi;

  localparam int unsigned CW = 8;
  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_sop, in_eop, out_ready;
  logic [CW-1:0] in_char;
  logic [NC*CW-1:0] match_val, match_hi;
  logic [NC*3-1:0] cmp_type;

  logic in_ready, out_valid, out_sop, out_eop, out_err;
  logic [CW-1:0] out_char;
  logic [NC-1:0] out_cmp;
  logic [NC*8-1:0] out_hit_cnt, out_first_pos;

  logic in_ready4, out_valid4, out_sop4, out_eop4, out_err4;
  logic [CW-1:0] out_char4;
  logic [NC-1:0] out_cmp4;
  logic [NC*4-1:0] out_hit_cnt4, out_first_pos4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cr_prefix_fe_cmp_multi #(.CHAR_W(CW), .NUM_CMP(NC), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_sop(in_sop), .in_eop(in_eop),
    .match_val(match_val), .match_hi(match_hi), .cmp_type(cmp_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_sop(out_sop), .out_eop(out_eop), .out_cmp(out_cmp),
    .out_hit_cnt(out_hit_cnt), .out_first_pos(out_first_pos), .out_err(out_err)
  );

  cr_prefix_fe_cmp_multi #(.CHAR_W(CW), .NUM_CMP(NC), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_char(in_char), .in_sop(in_sop), .in_eop(in_eop),
    .match_val(match_val), .match_hi(match_hi), .cmp_type(cmp_type),
    .out_valid(out_valid4), .out_ready(out_ready), .out_char(out_char4),
    .out_sop(out_sop4), .out_eop(out_eop4), .out_cmp(out_cmp4),
    .out_hit_cnt(out_hit_cnt4), .out_first_pos(out_first_pos4), .out_err(out_err4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rule(input int i, input logic [2:0] mode, input logic [7:0] v, input logic [7:0] h);
    match_val[i*8 +: 8] = v;
    match_hi[i*8 +: 8]  = h;
    cmp_type[i*3 +: 3]  = mode;
  endtask

  // Presents one beat for one clock; caller ensures in_ready is high
  task automatic beat(input logic [7:0] c, input logic s, input logic e);
    in_char  = c;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_char = '0; out_ready = 1'b1;
    match_val = '0; match_hi = '0; cmp_type = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_first_pos", out_first_pos, 32'hFFFF_FFFF);
    check("rst_hit_cnt", out_hit_cnt, 0);
    check("rst_out_cmp", out_cmp, 0);
    rst_n = 1'b1;

    set_rule(0, 3'd0, 8'h41, 8'h00);
    set_rule(1, 3'd4, 8'h30, 8'h39);
    set_rule(2, 3'd5, 8'h40, 8'hE0);
    set_rule(3, 3'd2, 8'h20, 8'h00);

    // Frame "A1b", no stall
    beat(8'h41, 1, 0);
    check("f1_A_valid", out_valid, 1);
    check("f1_A_cmp", out_cmp, 4'b0101);
    check("f1_A_hit", out_hit_cnt, 32'h0001_0001);
    check("f1_A_first", out_first_pos, 32'hFF00_FF00);
    check("f1_A_err", out_err, 0);
    beat(8'h31, 0, 0);
    check("f1_1_cmp", out_cmp, 4'b0010);
    check("f1_1_first", out_first_pos, 32'hFF00_0100);
    beat(8'h62, 0, 1);
    check("f1_b_cmp", out_cmp, 4'b0000);
    check("f1_b_hit", out_hit_cnt, 32'h0001_0101);
    check("f1_b_first", out_first_pos, 32'hFF00_0100);
    check("f1_b_eop", out_eop, 1);
    @(posedge clk);
    #1;
    check("drain_valid", out_valid, 0);
    check("drain_cmp", out_cmp, 0);

    // Same frame with a 3-cycle downstream stall after the first beat
    beat(8'h41, 1, 0);
    out_ready = 1'b0;
    in_char = 8'h31; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_char", out_char, 8'h41);
      check("stall_cmp", out_cmp, 4'b0101);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("stall_1_char", out_char, 8'h31);
    check("stall_1_cmp", out_cmp, 4'b0010);
    beat(8'h62, 0, 1);
    check("stall_b_hit", out_hit_cnt, 32'h0001_0101);
    check("stall_b_first", out_first_pos, 32'hFF00_0100);

    // Mid-frame config change is ignored until the next sop
    beat(8'h41, 1, 0);
    set_rule(0, 3'd0, 8'h62, 8'h00);
    beat(8'h41, 0, 0);
    check("shadow_A_cmp", out_cmp, 4'b0101);
    beat(8'h62, 0, 1);
    check("shadow_b_cmp", out_cmp, 4'b0000);
    check("shadow_b_hit0", out_hit_cnt[7:0], 2);
    beat(8'h62, 1, 1);
    check("newcfg_b_cmp", out_cmp, 4'b0001);
    check("newcfg_b_hit0", out_hit_cnt[7:0], 1);
    check("newcfg_b_err", out_err, 0);

    // Framing errors
    beat(8'h41, 0, 0);
    check("idle_nosop_err", out_err, 1);
    set_rule(0, 3'd0, 8'h41, 8'h00);
    beat(8'h41, 1, 0);
    check("sop_ok_err", out_err, 0);
    beat(8'h31, 0, 0);
    check("mid_err", out_err, 0);
    check("mid_first1", out_first_pos[15:8], 8'h01);
    beat(8'h41, 1, 0);
    check("resop_err", out_err, 1);
    check("resop_hit0", out_hit_cnt[7:0], 1);
    check("resop_first0", out_first_pos[7:0], 0);
    check("resop_hit1", out_hit_cnt[15:8], 0);
    check("resop_first1", out_first_pos[15:8], 8'hFF);
    beat(8'h41, 0, 1);
    check("resop_eop_err", out_err, 0);
    check("resop_eop_hit0", out_hit_cnt[7:0], 2);

    // Saturation: 19 'A' then 'B'; rule2 reserved, rule3 MASK with h=0
    set_rule(0, 3'd0, 8'h41, 8'h00);
    set_rule(1, 3'd0, 8'h42, 8'h00);
    set_rule(2, 3'd6, 8'h41, 8'hFF);
    set_rule(3, 3'd5, 8'hFF, 8'h00);
    for (int k = 0; k < 19; k++) beat(8'h41, k == 0, 0);
    beat(8'h42, 0, 1);
    check("sat_cmp", out_cmp, 4'b1010);
    check("sat4_hit", out_hit_cnt4, 16'hF01F);
    check("sat4_first", out_first_pos4, 16'h0FE0);
    check("sat8_hit", out_hit_cnt, 32'h1400_0113);
    check("sat8_first", out_first_pos, 32'h00FF_1300);

    // Reset while an output beat is held
    beat(8'h41, 1, 0);
    out_ready = 1'b0;
    check("prerst_valid", out_valid, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("midrst_valid", out_valid, 0);
    check("midrst_first", out_first_pos, 32'hFFFF_FFFF);
    check("midrst_in_ready", in_ready, 1);
    beat(8'h5A, 0, 0);
    check("midrst_idle_err", out_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
